// File: rtl/mem_access_unit_if.sv
// Avalon-style data bus between the load/store unit and the data RAM.
interface mem_access_unit_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front end: one CPU request becomes one bus transaction with
// lane-correct byteenable/writedata, and load data is aligned and extended.
module mem_access_unit #(
  parameter int RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cpu_valid,
  input  logic               cpu_write,
  input  logic [2:0]         cpu_op,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic               cpu_busy,
  output logic               cpu_done,
  output logic               cpu_fault,
  output logic [31:0]        cpu_rdata,
  mem_access_unit_if.master  bus
);

  typedef enum logic [1:0] {IDLE, BUS, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        fault_q, fault_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req_fault;
  logic [3:0]  be_lane;
  logic [31:0] wd_lane;
  logic [31:0] byte_sh;
  logic [15:0] half_sel;
  logic [31:0] ld_ext;
  logic        in_bus;

  // Classify the incoming request: misalignment, reserved ops, unsigned stores.
  always_comb begin
    req_fault = 1'b0;
    case (cpu_op)
      3'b000, 3'b100: req_fault = 1'b0;
      3'b001, 3'b101: req_fault = cpu_addr[0];
      3'b011:         req_fault = (cpu_addr[1:0] != 2'b00);
      default:        req_fault = 1'b1;
    endcase
    if (cpu_write && cpu_op[2])
      req_fault = 1'b1;
  end

  // Byte lanes and replicated store data for the latched request size.
  always_comb begin
    be_lane = 4'b1111;
    wd_lane = wdata_q;
    case (op_q[1:0])
      2'b00: begin
        be_lane = 4'b0001 << addr_q[1:0];
        wd_lane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_lane = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_lane = {2{wdata_q[15:0]}};
      end
      default: begin
        be_lane = 4'b1111;
        wd_lane = wdata_q;
      end
    endcase
  end

  // Shift the addressed byte/half down to bit 0 and extend by op signedness.
  always_comb begin
    byte_sh  = bus.readdata >> {addr_q[1:0], 3'b000};
    half_sel = addr_q[1] ? bus.readdata[31:16] : bus.readdata[15:0];
    case (op_q[1:0])
      2'b00:   ld_ext = op_q[2] ? {24'h0, byte_sh[7:0]}
                                : {{24{byte_sh[7]}}, byte_sh[7:0]};
      2'b01:   ld_ext = op_q[2] ? {16'h0, half_sel}
                                : {{16{half_sel[15]}}, half_sel};
      default: ld_ext = bus.readdata;
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          write_d = cpu_write;
          op_d    = cpu_op;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          fault_d = req_fault;
          state_d = req_fault ? DONE : BUS;
        end
      end
      BUS: begin
        if (!bus.waitrequest) begin
          if (write_q) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = 2'(RD_LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = ld_ext;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      op_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      fault_q <= 1'b0;
      cnt_q   <= 2'd0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus signals are only live in BUS, so they are zero everywhere else.
  assign in_bus         = (state_q == BUS);
  assign bus.read       = in_bus & ~write_q;
  assign bus.write      = in_bus &  write_q;
  assign bus.address    = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.byteenable = in_bus ? be_lane : 4'b0000;
  assign bus.writedata  = (in_bus && write_q) ? wd_lane : 32'h0;

  assign cpu_busy  = (state_q != IDLE);
  assign cpu_done  = (state_q == DONE);
  assign cpu_fault = (state_q == DONE) & fault_q;
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table plus stall/reset sequences,
// with a scoreboard queue checked on every cpu_done.
module tb_mem_access_unit;
  localparam int L = 1;

  typedef struct {
    int          id;
    logic        wr;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdv;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          lat;
    int          nbus;
    int          t0;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_valid, cpu_write;
  logic [2:0]  cpu_op;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_busy, cpu_done, cpu_fault;
  logic [31:0] cpu_rdata;

  int          stall_n;
  logic [31:0] rd_val;
  int          bus_cyc;
  logic [3:0]  rd_pipe;

  int   checks, errors;
  int   ncnt, done_cnt, done_exp;
  vec_t cur;
  vec_t exp_q[$];
  vec_t tbl[15];

  int          nbus;
  logic        cap_wr;
  logic [31:0] cap_addr, cap_wd;
  logic [3:0]  cap_be;

  mem_access_unit_if bus();

  mem_access_unit #(.RD_LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_op(cpu_op),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_fault(cpu_fault),
    .cpu_rdata(cpu_rdata), .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Slave model: stall_n wait cycles per access, read data valid L cycles after accept.
  always @(posedge clk) begin
    if (bus.read || bus.write) bus_cyc <= bus_cyc + 1;
    else                       bus_cyc <= 0;
    rd_pipe <= {rd_pipe[2:0], bus.read && !bus.waitrequest};
  end
  assign bus.waitrequest = (bus.read || bus.write) && (bus_cyc < stall_n);
  assign bus.readdata    = rd_pipe[L-1] ? rd_val : 32'h0BAD0BAD;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdv, input logic fault,
                              input logic [3:0] be, input logic [31:0] wd, input logic [31:0] rdata);
    vec_t v;
    v.id = 0; v.wr = wr; v.op = op; v.addr = addr; v.wdata = wdata; v.rdv = rdv;
    v.fault = fault; v.be = be; v.wd = wd; v.rdata = rdata;
    v.lat = 0; v.nbus = 0; v.t0 = 0;
    return v;
  endfunction

  // Scoreboard: push on observed acceptance, pop and compare on cpu_done.
  task automatic monitor();
    vec_t e;
    forever begin
      @(negedge clk);
      ncnt++;
      if (!reset_n) begin
        exp_q.delete();
        nbus = 0;
        continue;
      end
      if (bus.read || bus.write) begin
        chk("rd_wr_exclusive", {31'h0, bus.read & bus.write}, 32'h0);
        chk("busy_in_bus", {31'h0, cpu_busy}, 32'h1);
        if (nbus == 0) begin
          cap_wr = bus.write; cap_addr = bus.address;
          cap_be = bus.byteenable; cap_wd = bus.writedata;
        end else begin
          chk("bus_addr_stable", bus.address, cap_addr);
          chk("bus_be_stable", {28'h0, bus.byteenable}, {28'h0, cap_be});
          chk("bus_dir_stable", {31'h0, bus.write}, {31'h0, cap_wr});
        end
        nbus++;
      end
      if (cpu_valid && !cpu_busy) begin
        e = cur;
        e.t0 = ncnt;
        exp_q.push_back(e);
      end
      if (cpu_done) begin
        done_cnt++;
        chk("done_expected", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk($sformatf("v%0d_fault", e.id), {31'h0, cpu_fault}, {31'h0, e.fault});
          chk($sformatf("v%0d_latency", e.id), ncnt - e.t0, e.lat);
          chk($sformatf("v%0d_bus_cycles", e.id), nbus, e.nbus);
          if (!e.fault) begin
            chk($sformatf("v%0d_address", e.id), cap_addr, {e.addr[31:2], 2'b00});
            chk($sformatf("v%0d_byteenable", e.id), {28'h0, cap_be}, {28'h0, e.be});
            chk($sformatf("v%0d_direction", e.id), {31'h0, cap_wr}, {31'h0, e.wr});
            if (e.wr) chk($sformatf("v%0d_writedata", e.id), cap_wd, e.wd);
            else      chk($sformatf("v%0d_rdata", e.id), cpu_rdata, e.rdata);
          end
        end
        nbus = 0;
      end
    end
  endtask

  task automatic drive(input vec_t v);
    @(posedge clk); #1;
    cur = v;
    cur.lat  = v.fault ? 1 : (v.wr ? 2 + stall_n : 2 + L + stall_n);
    cur.nbus = v.fault ? 0 : 1 + stall_n;
    cpu_valid = 1'b1; cpu_write = v.wr; cpu_op = v.op;
    cpu_addr = v.addr; cpu_wdata = v.wdata; rd_val = v.rdv;
    done_exp++;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    chk("done_timeout", exp_q.size(), 0);
  endtask

  initial begin
    checks = 0; errors = 0; ncnt = 0; done_cnt = 0; done_exp = 0; nbus = 0;
    bus_cyc = 0; rd_pipe = 4'h0; stall_n = 0; rd_val = 32'h0;
    cur = mk(0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    reset_n = 1'b0; cpu_valid = 1'b0; cpu_write = 1'b0; cpu_op = 3'b000;
    cpu_addr = 32'h0; cpu_wdata = 32'h0;

    //           wr op      addr          wdata         readdata      flt be       wd            rdata
    tbl[0]  = mk(1, 3'b011, 32'hBFC00010, 32'hDEADBEEF, 32'h0,        0, 4'b1111, 32'hDEADBEEF, 32'h0);
    tbl[1]  = mk(0, 3'b000, 32'hBFC00013, 32'h0,        32'h80112233, 0, 4'b1000, 32'h0,        32'hFFFFFF80);
    tbl[2]  = mk(0, 3'b100, 32'hBFC00013, 32'h0,        32'h80112233, 0, 4'b1000, 32'h0,        32'h00000080);
    tbl[3]  = mk(1, 3'b001, 32'hBFC00006, 32'h0000ABCD, 32'h0,        0, 4'b1100, 32'hABCDABCD, 32'h0);
    tbl[4]  = mk(0, 3'b101, 32'hBFC00006, 32'h0,        32'hABCD0000, 0, 4'b1100, 32'h0,        32'h0000ABCD);
    tbl[5]  = mk(0, 3'b011, 32'hBFC00002, 32'h0,        32'h0,        1, 4'h0,    32'h0,        32'h0);
    tbl[6]  = mk(0, 3'b001, 32'hBFC00001, 32'h0,        32'h0,        1, 4'h0,    32'h0,        32'h0);
    tbl[7]  = mk(0, 3'b001, 32'hBFC00002, 32'h0,        32'h80001234, 0, 4'b1100, 32'h0,        32'hFFFF8000);
    tbl[8]  = mk(0, 3'b011, 32'hBFC00008, 32'h0,        32'h12345678, 0, 4'b1111, 32'h0,        32'h12345678);
    tbl[9]  = mk(1, 3'b000, 32'hBFC00002, 32'h123456C3, 32'h0,        0, 4'b0100, 32'hC3C3C3C3, 32'h0);
    tbl[10] = mk(0, 3'b010, 32'hBFC00000, 32'h0,        32'h0,        1, 4'h0,    32'h0,        32'h0);
    tbl[11] = mk(1, 3'b100, 32'hBFC00000, 32'h00000011, 32'h0,        1, 4'h0,    32'h0,        32'h0);
    tbl[12] = mk(0, 3'b100, 32'hBFC00001, 32'h0,        32'h0000F100, 0, 4'b0010, 32'h0,        32'h000000F1);
    tbl[13] = mk(0, 3'b001, 32'hBFC00000, 32'h0,        32'h12347FFF, 0, 4'b0011, 32'h0,        32'h00007FFF);
    tbl[14] = mk(0, 3'b000, 32'hBFC00000, 32'h0,        32'hFFFFFF7F, 0, 4'b0001, 32'h0,        32'h0000007F);
    for (int i = 0; i < 15; i++) tbl[i].id = i;

    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'h0, cpu_busy}, 32'h0);
    chk("reset_done", {31'h0, cpu_done}, 32'h0);
    chk("reset_rdata", cpu_rdata, 32'h0);
    chk("reset_bus", {bus.read, bus.write, bus.byteenable, 26'h0}, 32'h0);
    chk("reset_address", bus.address, 32'h0);
    chk("reset_writedata", bus.writedata, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i]);
      wait_done();
    end

    // Load held off by three wait cycles, with a stray request mid-flight.
    stall_n = 3;
    drive(mk(0, 3'b011, 32'hBFC00020, 32'h0, 32'hCAFEF00D, 0, 4'b1111, 32'h0, 32'hCAFEF00D));
    cur.id = 100;
    cpu_valid = 1'b1; cpu_write = 1'b1; cpu_op = 3'b011; cpu_addr = 32'hBFC00040;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    chk("stall_busy", {31'h0, cpu_busy}, 32'h1);
    wait_done();
    repeat (4) @(posedge clk);
    chk("stray_request_ignored", done_cnt, done_exp);

    // Reset while stalled in BUS abandons the read with no completion.
    stall_n = 20;
    drive(mk(0, 3'b011, 32'hBFC00030, 32'h0, 32'h0, 0, 4'b1111, 32'h0, 32'h0));
    done_exp--;
    @(posedge clk); #1;
    chk("pre_reset_read", {31'h0, bus.read}, 32'h1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_read", {31'h0, bus.read}, 32'h0);
    chk("abort_busy", {31'h0, cpu_busy}, 32'h0);
    chk("abort_done", {31'h0, cpu_done}, 32'h0);
    chk("abort_rdata", cpu_rdata, 32'h0);
    reset_n = 1'b1;
    stall_n = 0;
    repeat (3) @(posedge clk);
    chk("abort_no_done", done_cnt, done_exp);

    drive(mk(1, 3'b000, 32'hBFC00001, 32'h0000005A, 32'h0, 0, 4'b0010, 32'h5A5A5A5A, 32'h0));
    wait_done();
    repeat (3) @(posedge clk);
    chk("total_done_count", done_cnt, done_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end between the CPU datapath and the byte-addressed data RAM.
- Takes one MIPS load or store request and turns it into a single Avalon-style bus transaction with the correct byteenable and lane-replicated writedata.
- Honours waitrequest, then aligns and sign- or zero-extends the returned read data.
- Detects misaligned accesses and reserved op encodings and reports them as faults; no bus access is made for a fault.

Parameters:
- RD_LATENCY, 1, cycles from read accepted (read=1, waitrequest=0) until readdata is valid; legal values are 1..3.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  synchronous reset, active-low.
- cpu_valid  in  1  request strobe; sampled only in IDLE.
- cpu_write  in  1  1 = store, 0 = load.
- cpu_op  in  3  size code (low 3 bits of the MIPS opcode): 000 byte signed, 001 half signed, 011 word, 100 byte unsigned, 101 half unsigned.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data; the value is taken from the low bits.
- cpu_busy  out  1  high in every state except IDLE.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_fault  out  1  valid together with cpu_done; 1 = misaligned access or reserved op.
- cpu_rdata  out  32  extended load result; held until the next load completes.
- address  out  32  word-aligned bus address, {cpu_addr[31:2],2'b00}.
- read  out  1  bus read request.
- write  out  1  bus write request.
- byteenable  out  4  bit i enables bits 8i+7:8i.
- writedata  out  32  lane-replicated store data.
- waitrequest  in  1  slave stall.
- readdata  in  32  slave read data.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - Next state is IDLE, from any state.
  - All outputs are 0, including address, byteenable, writedata and cpu_rdata.
  - A transaction in flight is abandoned: read/write deassert at that edge and no cpu_done is produced.
- State machine: IDLE, BUS, WAIT, DONE.
- IDLE:
  - When cpu_valid=1, latch cpu_write, cpu_op, cpu_addr and cpu_wdata.
  - If the request is a fault, go to DONE with the fault flag set; otherwise go to BUS.
- Fault conditions:
  - op 001/101 with addr[0]=1.
  - op 011 with addr[1:0]≠00.
  - op 010, 110 or 111.
  - a store with op 100 or 101.
- BUS:
  - Drive read or write, address, byteenable and writedata, all stable.
  - Stay in BUS while waitrequest=1.
  - When waitrequest=0: a store goes to DONE; a load goes to WAIT with counter=RD_LATENCY-1.
- WAIT:
  - read=0.
  - If counter=0, capture readdata, extract and extend it into cpu_rdata, then go to DONE; otherwise decrement the counter.
- DONE:
  - cpu_done=1 for exactly one cycle and cpu_fault=flag, then go to IDLE.
  - cpu_done and cpu_fault are 0 in all other states.
- cpu_valid outside IDLE is ignored; requests are not queued.
- Store lanes (b = addr[1:0]):
  - Byte: byteenable = 0001<<b, writedata = {4{wdata[7:0]}}.
  - Half: byteenable = 0011 if addr[1]=0, else 1100; writedata = {2{wdata[15:0]}}.
  - Word: byteenable = 1111, writedata = wdata.
- Load extract:
  - byte = readdata[8b+7:8b].
  - half = readdata[16·addr[1]+15:16·addr[1]].
  - Extend by op: signed ops replicate the top bit, unsigned ops zero-fill.
  - For loads, byteenable is driven exactly as for a store of the same size.
- Latency with waitrequest=0 throughout, request accepted at edge T:
  - load: cpu_done at cycle T+2+RD_LATENCY.
  - store: cpu_done at cycle T+2.
  - fault: cpu_done at cycle T+1.
- read and write are never both 1. Bus signals are 0 in IDLE, WAIT and DONE, except that address and byteenable may hold their last value.

Test Plan:
- SW of 0xDEADBEEF to 0xBFC00010, waitrequest=0:
  - Required: write=1 for 1 cycle, address=0xBFC00010, byteenable=1111, writedata=0xDEADBEEF.
  - Required: cpu_done 2 cycles after acceptance, cpu_fault=0.
- LB from 0xBFC00013 with readdata=0x80112233, RD_LATENCY=1:
  - Required: byteenable=1000, address=0xBFC00010, cpu_rdata=0xFFFFFF80.
  - Repeat as LBU: cpu_rdata=0x00000080.
- SH of 0x0000ABCD to 0xBFC00006:
  - Required: byteenable=1100, writedata=0xABCDABCD, address=0xBFC00004.
  - Then LHU from the same address with readdata=0xABCD0000: cpu_rdata=0x0000ABCD.
- LW from 0xBFC00002, and LH from 0xBFC00001:
  - Required for each: no read/write asserted, cpu_done and cpu_fault both 1 one cycle after acceptance.
- LW with waitrequest held high for 3 cycles:
  - Required: read and address stable for all 4 BUS cycles, cpu_busy=1 throughout, cpu_done exactly once.
  - Required: a cpu_valid pulse presented mid-transaction is ignored.
- reset_n=0 while in BUS with waitrequest=1:
  - Required: read=0 at the next edge, state IDLE, cpu_done never asserted.
  - Required: a new SB of 0x5A to 0xBFC00001 then gives byteenable=0010, writedata=0x5A5A5A5A.
